// File: rtl/player_action_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : player_action_ctrl
//  Description : Per-player action sequencer between the cleaned button and
//                collision inputs and the player_attack timing engine.
//                Issues attack requests and holds them until the engine
//                acknowledges. Buffers one follow-up attack. Enforces the
//                cooldown and hitstun lockouts. Gates the movement and attack
//                enables so that the two never run together.
//  Ports       : clk, reset (async, active-high)
//                SCEN         - one-cycle frame pulse
//                game_active  - 0 freezes the player
//                atk1_btn/atk2_btn - debounced button levels
//                hit_in       - one-cycle hit pulse from collision logic
//                attack_busy  - attack engine animation in progress
//                atk_req, atk_type, attack_enable, move_enable,
//                attack_abort, buf_valid, ctrl_state - controls and status
//  Revision    : 1.0 - initial release
// ============================================================================
module player_action_ctrl #(
    parameter int COOLDOWN_FRAMES = 4,
    parameter int HITSTUN_FRAMES  = 12,
    parameter int ISSUE_TIMEOUT   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCEN,
    input  logic       game_active,
    input  logic       atk1_btn,
    input  logic       atk2_btn,
    input  logic       hit_in,
    input  logic       attack_busy,
    output logic       atk_req,
    output logic [1:0] atk_type,
    output logic       attack_enable,
    output logic       move_enable,
    output logic       attack_abort,
    output logic       buf_valid,
    output logic [2:0] ctrl_state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_ATTACK   = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_HITSTUN  = 3'd4
    } state_t;

    localparam logic [5:0] C_COOLDOWN = 6'(COOLDOWN_FRAMES);
    localparam logic [5:0] C_HITSTUN  = 6'(HITSTUN_FRAMES);
    localparam logic [5:0] C_TIMEOUT  = 6'(ISSUE_TIMEOUT);

    state_t     state;
    logic [5:0] cnt;
    logic [1:0] buf_type;
    logic       btn1_prev;
    logic       btn2_prev;

    // Press detection; ATK1 wins when both buttons rise together.
    logic       press1;
    logic       press2;
    logic       press_any;
    logic [1:0] press_type;

    assign press1     = atk1_btn & ~btn1_prev;
    assign press2     = atk2_btn & ~btn2_prev;
    assign press_any  = press1 | press2;
    assign press_type = press1 ? 2'd1 : 2'd2;

    // Shared frame counter expiry rule for COOLDOWN and HITSTUN: a load of
    // 0 or 1 exits on the first frame.
    logic cnt_expire;
    assign cnt_expire = (cnt <= 6'd1);

    // The edge registers keep sampling even while the game is frozen so a
    // button held across a resume does not look like a fresh press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn1_prev <= 1'b0;
            btn2_prev <= 1'b0;
        end else begin
            btn1_prev <= atk1_btn;
            btn2_prev <= atk2_btn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= 6'd0;
            atk_req      <= 1'b0;
            atk_type     <= 2'd0;
            attack_abort <= 1'b0;
            buf_valid    <= 1'b0;
            buf_type     <= 2'd0;
        end else begin
            attack_abort <= 1'b0;
            if (!game_active) begin
                state     <= ST_IDLE;
                cnt       <= 6'd0;
                atk_req   <= 1'b0;
                atk_type  <= 2'd0;
                buf_valid <= 1'b0;
                buf_type  <= 2'd0;
            end else if (hit_in) begin
                // Also covers a re-hit while already in HITSTUN: reload and
                // abort again.
                state        <= ST_HITSTUN;
                cnt          <= C_HITSTUN;
                atk_req      <= 1'b0;
                atk_type     <= 2'd0;
                attack_abort <= 1'b1;
                buf_valid    <= 1'b0;
                buf_type     <= 2'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (press_any) begin
                            state    <= ST_ISSUE;
                            atk_req  <= 1'b1;
                            atk_type <= press_type;
                            cnt      <= 6'd0;
                        end
                    end
                    ST_ISSUE: begin
                        // cnt counts frames spent waiting for acknowledge.
                        if (attack_busy) begin
                            state   <= ST_ATTACK;
                            atk_req <= 1'b0;
                            cnt     <= 6'd0;
                        end else if (SCEN) begin
                            if (cnt + 6'd1 >= C_TIMEOUT) begin
                                state    <= ST_IDLE;
                                atk_req  <= 1'b0;
                                atk_type <= 2'd0;
                                cnt      <= 6'd0;
                            end else begin
                                cnt <= cnt + 6'd1;
                            end
                        end
                    end
                    ST_ATTACK: begin
                        if (!attack_busy) begin
                            state <= ST_COOLDOWN;
                            cnt   <= C_COOLDOWN;
                        end
                        if (press_any && !buf_valid) begin
                            buf_valid <= 1'b1;
                            buf_type  <= press_type;
                        end
                    end
                    ST_COOLDOWN: begin
                        if (SCEN && cnt_expire) begin
                            cnt <= 6'd0;
                            if (buf_valid) begin
                                state     <= ST_ISSUE;
                                atk_req   <= 1'b1;
                                atk_type  <= buf_type;
                                buf_valid <= 1'b0;
                                buf_type  <= 2'd0;
                            end else if (press_any) begin
                                state    <= ST_ISSUE;
                                atk_req  <= 1'b1;
                                atk_type <= press_type;
                            end else begin
                                state    <= ST_IDLE;
                                atk_type <= 2'd0;
                            end
                        end else begin
                            if (SCEN) begin
                                cnt <= cnt - 6'd1;
                            end
                            if (press_any && !buf_valid) begin
                                buf_valid <= 1'b1;
                                buf_type  <= press_type;
                            end
                        end
                    end
                    ST_HITSTUN: begin
                        if (SCEN) begin
                            if (cnt_expire) begin
                                state <= ST_IDLE;
                                cnt   <= 6'd0;
                            end else begin
                                cnt <= cnt - 6'd1;
                            end
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        cnt      <= 6'd0;
                        atk_req  <= 1'b0;
                        atk_type <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign move_enable   = game_active && (state == ST_IDLE);
    assign attack_enable = game_active && (state != ST_HITSTUN);
    assign ctrl_state    = state;

endmodule
`default_nettype wire

// File: tb/tb_player_action_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_player_action_ctrl
//  Description : Directed self-checking bench for player_action_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_player_action_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       SCEN;
    logic       game_active;
    logic       atk1_btn;
    logic       atk2_btn;
    logic       hit_in;
    logic       attack_busy;
    logic       atk_req;
    logic [1:0] atk_type;
    logic       attack_enable;
    logic       move_enable;
    logic       attack_abort;
    logic       buf_valid;
    logic [2:0] ctrl_state;

    int vectors     = 0;
    int miscompares = 0;

    player_action_ctrl #(
        .COOLDOWN_FRAMES(4),
        .HITSTUN_FRAMES (12),
        .ISSUE_TIMEOUT  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .SCEN         (SCEN),
        .game_active  (game_active),
        .atk1_btn     (atk1_btn),
        .atk2_btn     (atk2_btn),
        .hit_in       (hit_in),
        .attack_busy  (attack_busy),
        .atk_req      (atk_req),
        .atk_type     (atk_type),
        .attack_enable(attack_enable),
        .move_enable  (move_enable),
        .attack_abort (attack_abort),
        .buf_valid    (buf_valid),
        .ctrl_state   (ctrl_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scen_pulse();
        SCEN = 1'b1;
        step();
        SCEN = 1'b0;
        step();
    endtask

    task automatic scen_n(input int n);
        for (int k = 0; k < n; k++) scen_pulse();
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; SCEN = 1'b0; game_active = 1'b1;
        atk1_btn = 1'b0; atk2_btn = 1'b0; hit_in = 1'b0; attack_busy = 1'b0;
        step(); step();
        reset = 1'b0;
        step();

        // Reset state
        chk("rst_state",  ctrl_state, 0);
        chk("rst_req",    atk_req, 0);
        chk("rst_type",   atk_type, 0);
        chk("rst_buf",    buf_valid, 0);
        chk("rst_abort",  attack_abort, 0);
        chk("rst_move",   move_enable, 1);
        chk("rst_atken",  attack_enable, 1);

        // Tap atk1 -> ISSUE
        atk1_btn = 1'b1; step();
        chk("iss_state",  ctrl_state, 1);
        chk("iss_req",    atk_req, 1);
        chk("iss_type",   atk_type, 1);
        chk("iss_move",   move_enable, 0);
        atk1_btn = 1'b0; step();
        attack_busy = 1'b1; step();
        chk("atk_state",  ctrl_state, 2);
        chk("atk_req",    atk_req, 0);

        // Buffer atk2, later atk1 ignored
        atk2_btn = 1'b1; step();
        chk("buf_load",   buf_valid, 1);
        atk2_btn = 1'b0; step();
        atk1_btn = 1'b1; step();
        atk1_btn = 1'b0; step();
        attack_busy = 1'b0; step();
        chk("cd_state",   ctrl_state, 3);
        scen_n(3);
        chk("cd_hold3",   ctrl_state, 3);
        scen_pulse();
        chk("cd_exit_st", ctrl_state, 1);
        chk("cd_exit_ty", atk_type, 2);
        chk("cd_exit_bf", buf_valid, 0);
        chk("cd_exit_rq", atk_req, 1);

        // No buffered press: back to IDLE after exactly 4 frames
        attack_busy = 1'b1; step();
        chk("atk2_state", ctrl_state, 2);
        attack_busy = 1'b0; step();
        scen_n(3);
        chk("cd2_hold3",  ctrl_state, 3);
        chk("cd2_move",   move_enable, 0);
        scen_pulse();
        chk("cd2_idle",   ctrl_state, 0);
        chk("cd2_move1",  move_enable, 1);
        chk("cd2_type0",  atk_type, 0);

        // Hit from IDLE: 12 frames of HITSTUN
        hit_in = 1'b1; step();
        hit_in = 1'b0;
        chk("hs0_state",  ctrl_state, 4);
        chk("hs0_atken",  attack_enable, 0);
        step();
        scen_n(11);
        chk("hs0_hold11", ctrl_state, 4);
        scen_pulse();
        chk("hs0_idle",   ctrl_state, 0);

        // Hit during ATTACK with a buffered press, re-hit at frame 6
        atk1_btn = 1'b1; step();
        atk1_btn = 1'b0; attack_busy = 1'b1; step();
        chk("hs_atk",     ctrl_state, 2);
        atk2_btn = 1'b1; step();
        atk2_btn = 1'b0;
        chk("hs_buf1",    buf_valid, 1);
        hit_in = 1'b1; step();
        hit_in = 1'b0;
        chk("hs_state",   ctrl_state, 4);
        chk("hs_abort",   attack_abort, 1);
        chk("hs_buf0",    buf_valid, 0);
        chk("hs_req0",    atk_req, 0);
        step();
        chk("hs_abort1c", attack_abort, 0);
        attack_busy = 1'b0;
        scen_n(5);
        SCEN = 1'b1; hit_in = 1'b1; step();
        SCEN = 1'b0; hit_in = 1'b0;
        chk("hs_reabort", attack_abort, 1);
        step();
        scen_n(10);                       // frames 7..16
        chk("hs_hold16",  ctrl_state, 4);
        scen_pulse();                     // frame 17
        chk("hs_hold17",  ctrl_state, 4);
        scen_pulse();                     // frame 18
        chk("hs_idle18",  ctrl_state, 0);

        // Issue timeout with no acknowledge
        atk1_btn = 1'b1; step();
        atk1_btn = 1'b0;
        chk("to_issue",   ctrl_state, 1);
        scen_pulse();
        chk("to_hold1",   ctrl_state, 1);
        scen_pulse();
        chk("to_idle",    ctrl_state, 0);
        chk("to_type0",   atk_type, 0);
        chk("to_req0",    atk_req, 0);

        // Simultaneous rise: ATK1 wins; then freeze mid-ATTACK
        atk1_btn = 1'b1; atk2_btn = 1'b1; step();
        chk("both_type",  atk_type, 1);
        atk1_btn = 1'b0; atk2_btn = 1'b0;
        attack_busy = 1'b1; step();
        chk("ga_atk",     ctrl_state, 2);
        game_active = 1'b0; step();
        chk("ga_state",   ctrl_state, 0);
        chk("ga_move",    move_enable, 0);
        chk("ga_atken",   attack_enable, 0);
        chk("ga_abort",   attack_abort, 0);
        step();
        chk("ga_abort2",  attack_abort, 0);
        game_active = 1'b1; attack_busy = 1'b0; step();
        chk("ga_resume",  move_enable, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/player_action_ctrl.md
Name: player_action_ctrl

Overview:
Per-player action sequencer that sits between the cleaned button and collision inputs and the player_attack timing engine. It decides when an attack may start and holds the attack request until the engine acknowledges it. It buffers one follow-up attack, and enforces cooldown and hitstun periods. It also gates movement and attack enables, so movement and attack never run at the same time.

Parameters:
COOLDOWN_FRAMES, 4, frames of recovery after the attack engine drops busy (minimum 1 effective)
HITSTUN_FRAMES, 12, frames the player is locked out after a hit
ISSUE_TIMEOUT, 2, SCEN frames to wait for attack_busy acknowledge before abandoning the request

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
SCEN  in  1  one-cycle pulse, once per video frame
game_active  in  1  level; 0 freezes the player (menu/KO)
atk1_btn  in  1  level, debounced upstream
atk2_btn  in  1  level, debounced upstream
hit_in  in  1  one-cycle pulse from collision logic: this player was hit
attack_busy  in  1  from attack engine: attack animation in progress
atk_req  out  1  level request to the attack engine (drives its attack1 input)
atk_type  out  2  0 none, 1 ATK1, 2 ATK2; valid while atk_req or in ATTACK
attack_enable  out  1  enable to the attack engine
move_enable  out  1  enable to the movement block
attack_abort  out  1  one-cycle pulse: kill the attack in progress (OR'd into the engine reset)
buf_valid  out  1  a follow-up attack is buffered
ctrl_state  out  3  0 IDLE, 1 ISSUE, 2 ATTACK, 3 COOLDOWN, 4 HITSTUN

Behaviour:
- Reset (async): state IDLE, atk_req=0, atk_type=0, attack_abort=0, buf_valid=0, all counters 0. Enables follow the combinational rules below (IDLE with game_active → move_enable=1, attack_enable=1).
- Press detection: a rising edge of atk1_btn or atk2_btn is detected on clk using registered previous values, which reset to 0. If both buttons rise in the same cycle, ATK1 wins. Held buttons never re-trigger.
- IDLE: a press edge moves to ISSUE on the next clk and latches atk_type. No SCEN is required.
- ISSUE: atk_req=1 and move_enable=0.
  - When attack_busy=1, go to ATTACK and drop atk_req in the same transition.
  - If ISSUE_TIMEOUT SCEN pulses pass without busy, go to IDLE with atk_type=0.
  - Press edges in ISSUE are ignored.
- ATTACK: move_enable=0. The first press edge loads a one-entry buffer (buf_valid=1 plus the buffered type); later presses are ignored while the buffer is full. When attack_busy falls, go to COOLDOWN and load the counter with COOLDOWN_FRAMES.
- COOLDOWN: move_enable=0, and press edges are still buffered.
  - On each SCEN, if the counter is ≤1 the state exits; otherwise the counter decrements. COOLDOWN_FRAMES of 0 or 1 therefore exits on the first SCEN.
  - On exit with buf_valid set: go to ISSUE with the buffered type and clear the buffer.
  - On exit with the buffer empty: go to IDLE with atk_type=0.
  - A press edge in the same cycle as exit with an empty buffer counts as buffered and goes to ISSUE.
- HITSTUN: entered from any state on hit_in.
  - On entry: attack_abort pulses for exactly 1 cycle, atk_req=0, buffer cleared, counter loaded with HITSTUN_FRAMES.
  - A hit_in while already in HITSTUN reloads the counter and pulses attack_abort again.
  - Exit to IDLE uses the same counter rule as COOLDOWN. Press edges are discarded.
- Enables (combinational from state):
  - move_enable = game_active && IDLE.
  - attack_enable = game_active && state≠HITSTUN.
- game_active=0: the next clk forces IDLE, clears atk_req, buffer and counters, and produces no abort pulse. While game_active=0, inputs are ignored except the edge-detect registers, which keep sampling.
- Priority within one cycle: reset > game_active=0 > hit_in > busy edge/counter expiry > press edge.
- Counters are 6 bits wide; parameters must be ≤63.

Test Plan:
- Reset, tap atk1 in IDLE → ISSUE next clk with atk_req=1, atk_type=1, move_enable=0. Then raise attack_busy → ATTACK and atk_req=0.
- In ATTACK press atk2 then atk1, drop busy → COOLDOWN. After 4 SCENs → ISSUE with atk_type=2 and buf_valid=0.
- No buffered press → after busy falls, exactly 4 SCENs later state returns to IDLE and move_enable=1.
- hit_in during ATTACK with buf_valid=1 → attack_abort high 1 cycle, buf_valid=0, HITSTUN; IDLE after 12 SCENs. A second hit at SCEN 6 extends the exit to SCEN 18.
- Request with attack_busy held 0 → IDLE after 2 SCENs with atk_type=0.
- Both buttons rise together → atk_type=1. Then game_active=0 mid-ATTACK → IDLE, both enables 0, no abort pulse.
